// File: rtl/uart_rx.sv
// uart_rx - asynchronous serial receiver.
//
// Deserializes a UART line (start bit, DATA_BIT data bits LSB first, optional
// parity bit, STOP_BIT stop bits) into parallel words. Each received frame is
// delivered as a one-cycle o_valid strobe together with its error flags, even
// when the frame carries errors.
//
// Ports:
//   i_clk        system clock
//   i_reset      asynchronous reset, active-high
//   i_rxd        serial line, idle high, asynchronous to i_clk
//   o_data       last received word (LSB = first data bit on the line)
//   o_valid      one-cycle strobe; o_data and flags are valid on this cycle
//   o_check_err  parity mismatch on the last frame (0 when CHECK_BIT="None")
//   o_frame_err  first stop bit of the last frame was sampled low
//   o_busy       high whenever the receiver is not idle
module uart_rx #(
    parameter string CHECK_BIT = "None",
    parameter int    BPS       = 115200,
    parameter int    CLK       = 25_000_000,
    parameter int    DATA_BIT  = 8,
    parameter int    STOP_BIT  = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_rxd,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_valid,
    output logic                o_check_err,
    output logic                o_frame_err,
    output logic                o_busy
);

    localparam int P     = CLK / BPS;
    localparam int HALF  = P / 2;
    localparam int CNT_W = (P > 1) ? $clog2(P) : 1;
    localparam int IDX_W = $clog2(DATA_BIT);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(P - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BIT - 1);

    localparam bit PAR_EN  = (CHECK_BIT != "None");
    localparam bit PAR_ODD = (CHECK_BIT == "Odd");

    // Only the first stop bit is checked; extra stop bits simply look like idle line.
    if (STOP_BIT < 1) begin : g_bad_stop
        $error("uart_rx: STOP_BIT must be at least 1");
    end
    if ((DATA_BIT < 6) || (DATA_BIT > 8)) begin : g_bad_data
        $error("uart_rx: DATA_BIT must be 6..8");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // Expected parity bit as the transmitter encodes it.
    function automatic logic exp_parity(input logic [DATA_BIT-1:0] d);
        if (PAR_ODD) begin
            exp_parity = ~^d;
        end else begin
            exp_parity = ^d;
        end
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_BIT-1:0] shift_q, shift_d;
    logic                chk_err_q, chk_err_d;
    logic                rxd_meta_q, rxd_meta_d;
    logic                rxd_sync_q, rxd_sync_d;
    logic                rxd_prev_q, rxd_prev_d;
    logic [DATA_BIT-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                check_err_q, check_err_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;
    logic                fall_s;
    logic                strobe_s;

    assign fall_s   = rxd_prev_q & ~rxd_sync_q;
    assign strobe_s = (state_q != S_IDLE) && (cnt_q == CNT_HALF);

    // Next-state logic: synchronizer chain, baud counter and the frame FSM.
    always_comb begin
        rxd_meta_d  = i_rxd;
        rxd_sync_d  = rxd_meta_q;
        rxd_prev_d  = rxd_sync_q;
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        chk_err_d   = chk_err_q;
        data_d      = data_q;
        check_err_d = check_err_q;
        frame_err_d = frame_err_q;
        valid_d     = 1'b0;

        // Counter free-runs modulo P outside IDLE so bit k lands at HALF + k*P.
        if (state_q == S_IDLE) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (fall_s) begin
                    state_d   = S_START;
                    idx_d     = {IDX_W{1'b0}};
                    chk_err_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (strobe_s) begin
                    // A line already back high at mid start bit is a glitch.
                    if (!rxd_sync_q) begin
                        state_d = S_DATA;
                        idx_d   = {IDX_W{1'b0}};
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (strobe_s) begin
                    shift_d = {rxd_sync_q, shift_q[DATA_BIT-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = {IDX_W{1'b0}};
                        state_d = PAR_EN ? S_CHECK : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHECK: begin
                if (strobe_s) begin
                    if (rxd_sync_q != exp_parity(shift_q)) begin
                        chk_err_d = 1'b1;
                    end else begin
                        chk_err_d = chk_err_q;
                    end
                    state_d = S_STOP;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_STOP: begin
                if (strobe_s) begin
                    data_d      = shift_q;
                    check_err_d = chk_err_q;
                    frame_err_d = ~rxd_sync_q;
                    valid_d     = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            shift_q     <= {DATA_BIT{1'b0}};
            chk_err_q   <= 1'b0;
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            rxd_prev_q  <= 1'b1;
            data_q      <= {DATA_BIT{1'b0}};
            valid_q     <= 1'b0;
            check_err_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            chk_err_q   <= chk_err_d;
            rxd_meta_q  <= rxd_meta_d;
            rxd_sync_q  <= rxd_sync_d;
            rxd_prev_q  <= rxd_prev_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            check_err_q <= check_err_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_check_err = check_err_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: three instances (8N1, 8E1, fast 8O2 loopback) share
// clock and reset; a scoreboard queue per instance is filled by the stimulus
// and drained by a monitor whenever that instance strobes o_valid.
module tb_uart_rx;

    localparam int CLK_HZ = 25_000_000;
    localparam int P_SLOW = CLK_HZ / 115200;     // 217
    localparam int P_FAST = CLK_HZ / 2_500_000;  // 10
    localparam int LAT_8N1 = 4 + P_SLOW / 2 + 9 * P_SLOW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rxd = 3'b111;

    logic [7:0] d_n, d_e, d_o;
    logic       v_n, v_e, v_o;
    logic       ce_n, ce_e, ce_o;
    logic       fe_n, fe_e, fe_o;
    logic       b_n, b_e, b_o;

    typedef struct packed {
        logic [7:0] d;
        logic       ce;
        logic       fe;
    } exp_t;

    exp_t q_n[$];
    exp_t q_e[$];
    exp_t q_o[$];

    int errors = 0;
    int checks = 0;

    always #20 clk = ~clk;

    uart_rx #(.CHECK_BIT("None"), .BPS(115200), .CLK(CLK_HZ), .DATA_BIT(8), .STOP_BIT(1)) dut_n (
        .i_clk(clk), .i_reset(rst), .i_rxd(rxd[0]), .o_data(d_n), .o_valid(v_n),
        .o_check_err(ce_n), .o_frame_err(fe_n), .o_busy(b_n));

    uart_rx #(.CHECK_BIT("Even"), .BPS(115200), .CLK(CLK_HZ), .DATA_BIT(8), .STOP_BIT(1)) dut_e (
        .i_clk(clk), .i_reset(rst), .i_rxd(rxd[1]), .o_data(d_e), .o_valid(v_e),
        .o_check_err(ce_e), .o_frame_err(fe_e), .o_busy(b_e));

    uart_rx #(.CHECK_BIT("Odd"), .BPS(2_500_000), .CLK(CLK_HZ), .DATA_BIT(8), .STOP_BIT(2)) dut_o (
        .i_clk(clk), .i_reset(rst), .i_rxd(rxd[2]), .o_data(d_o), .o_valid(v_o),
        .o_check_err(ce_o), .o_frame_err(fe_o), .o_busy(b_o));

    function automatic exp_t mk(input logic [7:0] d, input logic ce, input logic fe);
        mk = {d, ce, fe};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One bit time on channel ch, starting just after a rising edge.
    task automatic send_bit(input int ch, input logic b);
        int per;
        per = (ch == 2) ? P_FAST : P_SLOW;
        @(posedge clk);
        #1;
        rxd[ch] = b;
        repeat (per - 1) @(posedge clk);
    endtask

    task automatic send_frame(input int ch, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop0, input int nstop);
        send_bit(ch, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(ch, d[i]);
        if (has_par) send_bit(ch, par);
        send_bit(ch, stop0);
        for (int i = 1; i < nstop; i++) send_bit(ch, 1'b1);
    endtask

    // Scoreboard monitors: pop and compare on every o_valid strobe.
    always @(negedge clk) begin : mon_n
        exp_t e;
        if (v_n) begin
            if (q_n.size() == 0) begin
                chk("n_spurious_valid", {31'd0, v_n}, 32'd0);
            end else begin
                e = q_n.pop_front();
                chk("n_data", {24'd0, d_n}, {24'd0, e.d});
                chk("n_check_err", {31'd0, ce_n}, {31'd0, e.ce});
                chk("n_frame_err", {31'd0, fe_n}, {31'd0, e.fe});
            end
        end
    end

    always @(negedge clk) begin : mon_e
        exp_t e;
        if (v_e) begin
            if (q_e.size() == 0) begin
                chk("e_spurious_valid", {31'd0, v_e}, 32'd0);
            end else begin
                e = q_e.pop_front();
                chk("e_data", {24'd0, d_e}, {24'd0, e.d});
                chk("e_check_err", {31'd0, ce_e}, {31'd0, e.ce});
                chk("e_frame_err", {31'd0, fe_e}, {31'd0, e.fe});
            end
        end
    end

    always @(negedge clk) begin : mon_o
        exp_t e;
        if (v_o) begin
            if (q_o.size() == 0) begin
                chk("o_spurious_valid", {31'd0, v_o}, 32'd0);
            end else begin
                e = q_o.pop_front();
                chk("o_data", {24'd0, d_o}, {24'd0, e.d});
                chk("o_check_err", {31'd0, ce_o}, {31'd0, e.ce});
                chk("o_frame_err", {31'd0, fe_o}, {31'd0, e.fe});
            end
        end
    end

    initial begin : watchdog
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        logic [7:0] c3;

        // Reset values on all instances.
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_data_n", {24'd0, d_n}, 32'd0);
        chk("rst_valid_n", {31'd0, v_n}, 32'd0);
        chk("rst_busy_n", {31'd0, b_n}, 32'd0);
        chk("rst_flags_n", {30'd0, ce_n, fe_n}, 32'd0);
        chk("rst_flags_e", {30'd0, ce_e, fe_e}, 32'd0);
        chk("rst_busy_o", {31'd0, b_o}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Basic 8N1 frame with exact o_valid latency.
        q_n.push_back(mk(8'hA5, 1'b0, 1'b0));
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
            begin
                @(posedge clk);
                n = 0;
                while (n < 3000) begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                    if (v_n) break;
                end
                chk("basic_latency", n, LAT_8N1);
            end
        join
        @(negedge clk);
        chk("basic_busy_after", {31'd0, b_n}, 32'd0);

        // Even parity: correct then corrupted check bit.
        q_e.push_back(mk(8'h3C, 1'b0, 1'b0));
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, 1);
        q_e.push_back(mk(8'h3C, 1'b1, 1'b0));
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, 1);
        send_bit(1, 1'b1);
        @(negedge clk);
        chk("even_flag_hold", {31'd0, ce_e}, 32'd1);

        // Framing error then clean frame.
        q_n.push_back(mk(8'h55, 1'b0, 1'b1));
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1);
        send_bit(0, 1'b1);
        q_n.push_back(mk(8'h0F, 1'b0, 1'b0));
        send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1, 1);
        send_bit(0, 1'b1);

        // Glitch: 50 low cycles must not produce a frame.
        @(posedge clk);
        #1;
        rxd[0] = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_seen", {31'd0, b_n}, 32'd1);
        @(posedge clk);
        #1;
        rxd[0] = 1'b1;
        n = 0;
        while (n < P_SLOW) begin
            @(negedge clk);
            n++;
            if (!b_n) break;
        end
        chk("glitch_busy_clear", {31'd0, b_n}, 32'd0);
        repeat (P_SLOW) @(posedge clk);

        // Reset in the middle of data bit 3.
        c3 = 8'hC3;
        send_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, c3[i]);
        @(posedge clk);
        #1;
        rxd[0] = c3[3];
        repeat (P_SLOW / 2) @(posedge clk);
        @(negedge clk);
        chk("midframe_busy", {31'd0, b_n}, 32'd1);
        rst = 1'b1;
        rxd[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_data_n", {24'd0, d_n}, 32'd0);
        chk("midrst_valid_n", {31'd0, v_n}, 32'd0);
        chk("midrst_busy_n", {31'd0, b_n}, 32'd0);
        chk("midrst_flags_e", {30'd0, ce_e, fe_e}, 32'd0);
        rst = 1'b0;
        repeat (2 * P_SLOW) @(posedge clk);
        q_n.push_back(mk(8'hC3, 1'b0, 1'b0));
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 1);
        send_bit(0, 1'b1);

        // Loopback-style back-to-back 8O2 stream 0x00..0xFF.
        for (int d = 0; d < 256; d++) begin
            q_o.push_back(mk(8'(d), 1'b0, 1'b0));
            send_frame(2, 8'(d), 1'b1, ~^(8'(d)), 1'b1, 2);
        end
        repeat (50) @(posedge clk);

        // Every expected frame must have been delivered.
        chk("n_queue_drained", q_n.size(), 32'd0);
        chk("e_queue_drained", q_e.size(), 32'd0);
        chk("o_queue_drained", q_o.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
